// File: rtl/immediate_decode_stage.sv
// LEGv8 immediate decode stage: extracts and extends the immediate field, computes
// the PC-relative branch target, and holds the result in a one-entry valid/ready register.
module immediate_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [63:0] pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] imm,
  output logic [2:0]  imm_fmt,
  output logic [63:0] br_target,
  output logic [63:0] out_pc
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_D     = 3'd2;
  localparam logic [2:0] FMT_CB    = 3'd3;
  localparam logic [2:0] FMT_B     = 3'd4;
  localparam logic [2:0] FMT_SHAMT = 3'd5;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  fmt_next;
  logic [63:0] imm_next;
  logic [63:0] target_next;
  logic        accept;
  logic        consume;

  // Format decode; the first matching opcode group wins.
  always_comb begin
    fmt_next = FMT_NONE;
    imm_next = 64'd0;
    if (instr[31:26] == 6'b000101 || instr[31:26] == 6'b100101) begin
      fmt_next = FMT_B;
      imm_next = {{38{instr[25]}}, instr[25:0]};
    end else if (instr[31:24] == 8'b10110100 || instr[31:24] == 8'b10110101 ||
                 instr[31:24] == 8'b01010100) begin
      fmt_next = FMT_CB;
      imm_next = {{45{instr[23]}}, instr[23:5]};
    end else if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
      fmt_next = FMT_D;
      imm_next = {{55{instr[20]}}, instr[20:12]};
    end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100 ||
                 instr[31:22] == 10'b1001001000 || instr[31:22] == 10'b1011001000) begin
      fmt_next = FMT_I;
      imm_next = {52'd0, instr[21:10]};
    end else if (instr[31:21] == 11'b11010011011 || instr[31:21] == 11'b11010011010) begin
      fmt_next = FMT_SHAMT;
      imm_next = {58'd0, instr[15:10]};
    end
  end

  // Branch offsets are word-scaled; the add wraps modulo 2^64.
  always_comb begin
    target_next = 64'd0;
    if (fmt_next == FMT_B || fmt_next == FMT_CB) begin
      target_next = pc + {imm_next[61:0], 2'b00};
    end
  end

  assign out_valid = (state_reg == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY:   if (accept) state_next = FULL;
        FULL:    if (consume && !accept) state_next = EMPTY;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Data registers only move on accept, so they hold under stall and while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm       <= 64'd0;
      imm_fmt   <= FMT_NONE;
      br_target <= 64'd0;
      out_pc    <= 64'd0;
    end else if (accept) begin
      imm       <= imm_next;
      imm_fmt   <= fmt_next;
      br_target <= target_next;
      out_pc    <= pc;
    end
  end

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Directed self-checking bench for immediate_decode_stage: decode formats,
// branch target wrap, backpressure, back-to-back transfer, flush and async reset.
module tb_immediate_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] imm;
  logic [2:0]  imm_fmt;
  logic [63:0] br_target;
  logic [63:0] out_pc;

  int checks = 0;
  int errors = 0;

  immediate_decode_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm       (imm),
    .imm_fmt   (imm_fmt),
    .br_target (br_target),
    .out_pc    (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; pc = 64'd0; flush = 1'b0; out_ready = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || imm !== 64'd0 || imm_fmt !== 3'd0 || br_target !== 64'd0 ||
        out_pc !== 64'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b imm=%h fmt=%0d tgt=%h pc=%h rdy=%b required all zero, rdy=1",
               out_valid, imm, imm_fmt, br_target, out_pc, in_ready);
    end
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: valid=%b rdy=%b required valid=0 rdy=1", out_valid, in_ready);
    end
    $display("reset: done");
  endtask

  task automatic test_formats();
    logic [31:0] v_instr [14];
    logic [63:0] v_pc    [14];
    logic [2:0]  v_fmt   [14];
    logic [63:0] v_imm   [14];
    logic [63:0] v_tgt   [14];
    v_instr = '{32'hF85FF000, 32'h17FFFFFF, 32'hB4000200, 32'h913FFC00, 32'h00000000,
                32'hD360A800, 32'h54FFFFE0, 32'hF8005000, 32'h94000001, 32'hB5000020,
                32'h14000010, 32'hD1000400, 32'hB2200000, 32'hD340FC00};
    v_pc    = '{64'h40, 64'h100, 64'h200, 64'h300, 64'h400, 64'h500, 64'h600, 64'h700,
                64'h0, 64'h10, 64'hFFFF_FFFF_FFFF_FFF0, 64'h800, 64'h900, 64'hA00};
    v_fmt   = '{3'd2, 3'd4, 3'd3, 3'd1, 3'd0, 3'd5, 3'd3, 3'd2, 3'd4, 3'd3, 3'd4, 3'd1, 3'd1, 3'd5};
    v_imm   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hFFF, 64'h0,
                64'h2A, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 64'h1, 64'h1, 64'h10, 64'h1, 64'h800, 64'h3F};
    v_tgt   = '{64'h0, 64'hFC, 64'h240, 64'h0, 64'h0, 64'h0, 64'h5FC, 64'h0, 64'h4, 64'h14,
                64'h30, 64'h0, 64'h0, 64'h0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      instr = v_instr[i];
      pc    = v_pc[i];
      step();
      checks++;
      if (out_valid !== 1'b1 || imm_fmt !== v_fmt[i] || imm !== v_imm[i] ||
          br_target !== v_tgt[i] || out_pc !== v_pc[i]) begin
        errors++;
        $display("FAIL format_%0d: valid=%b fmt=%0d imm=%h tgt=%h pc=%h required valid=1 fmt=%0d imm=%h tgt=%h pc=%h",
                 i, out_valid, imm_fmt, imm, br_target, out_pc, v_fmt[i], v_imm[i], v_tgt[i], v_pc[i]);
      end else begin
        $display("format_%0d: instr=%h fmt=%0d imm=%h tgt=%h", i, v_instr[i], imm_fmt, imm, br_target);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'hA00) begin
      errors++;
      $display("FAIL drain: valid=%b pc=%h required valid=0 pc=a00", out_valid, out_pc);
    end
  endtask

  task automatic test_back_to_back();
    // Load A and stall it.
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'hB4000200; pc = 64'h200;
    step();
    instr = 32'h17FFFFFF; pc = 64'h100;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready_%0d: in_ready=%b required 0", c, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || imm !== 64'h10 || imm_fmt !== 3'd3 || br_target !== 64'h240 ||
          out_pc !== 64'h200) begin
        errors++;
        $display("FAIL stall_hold_%0d: valid=%b imm=%h fmt=%0d tgt=%h pc=%h required 1 10 3 240 200",
                 c, out_valid, imm, imm_fmt, br_target, out_pc);
      end else begin
        $display("stall_%0d: held pc=%h", c, out_pc);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: in_ready=%b required 1", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || imm_fmt !== 3'd4 || br_target !== 64'hFC || out_pc !== 64'h100) begin
      errors++;
      $display("FAIL b2b_first: valid=%b fmt=%0d tgt=%h pc=%h required 1 4 fc 100",
               out_valid, imm_fmt, br_target, out_pc);
    end
    instr = 32'h913FFC00; pc = 64'h300;
    step();
    checks++;
    if (out_valid !== 1'b1 || imm_fmt !== 3'd1 || imm !== 64'hFFF || out_pc !== 64'h300) begin
      errors++;
      $display("FAIL b2b_second: valid=%b fmt=%0d imm=%h pc=%h required 1 1 fff 300",
               out_valid, imm_fmt, imm, out_pc);
    end else begin
      $display("back_to_back: pc=%h imm=%h", out_pc, imm);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'hF8005000; pc = 64'h700;
    step();
    flush = 1'b1; out_ready = 1'b1; instr = 32'h94000001; pc = 64'h0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'h700 || imm !== 64'h5) begin
      errors++;
      $display("FAIL flush_full: valid=%b pc=%h imm=%h required 0 700 5", out_valid, out_pc, imm);
    end
    // Flush while empty with an offer: still dropped.
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'h700) begin
      errors++;
      $display("FAIL flush_empty: valid=%b pc=%h required 0 700", out_valid, out_pc);
    end
    flush = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: valid=%b required 0", out_valid);
    end else begin
      $display("flush: offered instruction dropped");
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'hB4000200; pc = 64'h200;
    step();
    instr = 32'h17FFFFFF; pc = 64'h100;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imm !== 64'd0 || imm_fmt !== 3'd0 || br_target !== 64'd0 ||
        out_pc !== 64'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: valid=%b imm=%h fmt=%0d tgt=%h pc=%h rdy=%b required zeros rdy=1",
               out_valid, imm, imm_fmt, br_target, out_pc, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'd0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b pc=%h required 0 0", out_valid, out_pc);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'd0) begin
      errors++;
      $display("FAIL reset_after: valid=%b pc=%h required 0 0", out_valid, out_pc);
    end else begin
      $display("async_reset: held instruction discarded");
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/immediate_decode_stage.md
IMMEDIATE_DECODE_STAGE -- requirements
Module: immediate_decode_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be cleared immediately on reset assertion, independent of the clock.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  instr/pc valid this cycle.
REQ-005 in_ready  output  1  stage can accept an input this cycle.
REQ-006 instr  input  32  LEGv8 instruction word.
REQ-007 pc  input  64  address of instr.
REQ-008 flush  input  1  discard the held instruction (branch mispredict/exception).
REQ-009 out_valid  output  1  registered outputs hold a decoded instruction.
REQ-010 out_ready  input  1  downstream accepts the output this cycle.
REQ-011 imm  output  64  extended immediate.
REQ-012 imm_fmt  output  3  0 NONE, 1 I, 2 D, 3 CB, 4 B, 5 SHAMT.
REQ-013 br_target  output  64  pc + (imm << 2) for CB/B; 0 otherwise.
REQ-014 out_pc  output  64  pc of the held instruction.

Function
REQ-015 Format decode, first match wins:
- B/BL: instr[31:26] = 000101 or 100101 -> B, imm = sign-extend instr[25:0].
- CB: instr[31:24] = 10110100, 10110101 (CBZ/CBNZ) or 01010100 (B.cond) -> CB, imm = sign-extend instr[23:5].
- D: instr[31:21] = 11111000010 or 11111000000 (LDUR/STUR) -> D, imm = sign-extend instr[20:12].
- I: instr[31:22] = 1001000100, 1101000100, 1001001000 or 1011001000 -> I, imm = zero-extend instr[21:10].
- SHAMT: instr[31:21] = 11010011011 or 11010011010 -> SHAMT, imm = zero-extend instr[15:10].
- Otherwise -> NONE, imm = 0.
REQ-016 br_target SHALL be computed modulo 2^64, wrapping with no overflow flag.
REQ-017 The stage SHALL be a single output register with a valid/ready handshake; latency is 1 cycle from input acceptance to out_valid.
REQ-018 in_ready = !out_valid || out_ready (combinational); an input is accepted when in_valid && in_ready.
REQ-019 An output is consumed when out_valid && out_ready; if an input is accepted in the same cycle, the register SHALL load the new result and out_valid SHALL remain 1.
REQ-020 While out_valid && !out_ready, imm, imm_fmt, br_target and out_pc SHALL hold stable.
REQ-021 On a flush edge, out_valid SHALL clear to 0 and any input offered in that cycle SHALL be dropped, even if in_ready = 1.
REQ-022 If out_valid = 0, the data outputs SHALL hold their previous values (don't-care to consumers).
REQ-023 The stage SHALL have 2 states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
- EMPTY -> FULL on accept.
- FULL -> EMPTY on consume without accept, or on flush.
- FULL -> FULL on accept, or on stall.

Reset
REQ-024 While rst_n = 0: out_valid = 0, imm = 0, imm_fmt = 0, br_target = 0, out_pc = 0; in_ready = 1 after reset.
REQ-025 Reset asserted mid-operation SHALL discard the held instruction with no output handshake completing.

Verification
REQ-026 LDUR, instr[20:12] = 9'h1FF, pc = 0x40, out_ready = 1 -> next cycle out_valid = 1, imm_fmt = 2, imm = 0xFFFFFFFFFFFFFFFF, br_target = 0.
REQ-027 B, instr[25:0] = 26'h3FFFFFF, pc = 0x100 -> imm = -1, imm_fmt = 4, br_target = 0xFC.
REQ-028 CBZ, instr[23:5] = 19'h00010, pc = 0x200 -> imm = 0x10, imm_fmt = 3, br_target = 0x240.
REQ-029 ADDI, imm12 = 0xFFF -> imm = 0xFFF (zero-extended), imm_fmt = 1; undefined opcode 0x00000000 -> imm_fmt = 0, imm = 0.
REQ-030 Backpressure: out_ready = 0 for 3 cycles while FULL -> in_ready = 0, outputs stable; then out_ready = 1 together with a new in_valid -> back-to-back transfer with no bubble.
REQ-031 Flush or rst_n = 0 while FULL with in_valid = 1 -> out_valid = 0 next cycle (immediately for reset); the offered instruction never appears.
